mem_bus_arbiter: RTL

//  Shares one single-port synchronous 16-bit RAM between two requesters:

---
 rtl/mem_bus_arbiter_if.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both requester ports and the RAM-side bus of mem_bus_arbiter.
// The arbiter connects through the slave modport; requesters and RAM use master.
interface mem_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM (port 0 = CPU, port 1 = I/O/DMA).
// Define MEM_ARB_RR_EN for round-robin; otherwise fixed priority with MAX_WAIT starvation bound.
module mem_bus_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_gnt;
  logic [1:0]    r_rvalid;
  logic [DW-1:0] r_rdata [2];
  logic          r_owner;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;

  logic [1:0]    w_req;
  logic          w_we    [2];
  logic [AW-1:0] w_addr  [2];
  logic [DW-1:0] w_wdata [2];
  logic          w_winner;

  assign w_req      = {bus.p1_req, bus.p0_req};
  assign w_we[0]    = bus.p0_we;
  assign w_we[1]    = bus.p1_we;
  assign w_addr[0]  = bus.p0_addr;
  assign w_addr[1]  = bus.p1_addr;
  assign w_wdata[0] = bus.p0_wdata;
  assign w_wdata[1] = bus.p1_wdata;

`ifdef MEM_ARB_RR_EN
  logic r_last_winner;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    w_winner = w_req[1];
    if (&w_req) begin
      w_winner = ~r_last_winner;
    end
  end
`else
  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [WCW-1:0] r_wait_cnt;

  // Port 0 wins unless port 1 has been held off long enough to be forced through.
  always_comb begin
    w_winner = w_req[1] && (!w_req[0] || (r_wait_cnt == WCW'(MAX_WAIT)));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_gnt[1]) begin
      r_wait_cnt <= '0;
    end else if (w_req[1] && (r_wait_cnt != WCW'(MAX_WAIT))) begin
      r_wait_cnt <= r_wait_cnt + WCW'(1);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata[0]  <= '0;
      r_rdata[1]  <= '0;
      r_owner     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_winner <= 1'b1;
`endif
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_owner         <= w_winner;
            r_mem_addr      <= w_addr[w_winner];
            r_mem_wdata     <= w_wdata[w_winner];
            r_mem_we        <= w_we[w_winner];
            r_gnt[w_winner] <= 1'b1;
            r_state         <= ST_ACCESS;
`ifdef MEM_ARB_RR_EN
            r_last_winner   <= w_winner;
`endif
          end
        end
        ST_ACCESS: begin
          r_mem_we <= 1'b0;
          r_state  <= r_mem_we ? ST_IDLE : ST_RDWAIT;
        end
        ST_RDWAIT: begin
          // RAM output is valid now, one cycle after the address went out.
          r_rdata[r_owner]  <= bus.mem_rdata;
          r_rvalid[r_owner] <= 1'b1;
          r_state           <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.p0_gnt    = r_gnt[0];
  assign bus.p1_gnt    = r_gnt[1];
  assign bus.p0_rvalid = r_rvalid[0];
  assign bus.p1_rvalid = r_rvalid[1];
  assign bus.p0_rdata  = r_rdata[0];
  assign bus.p1_rdata  = r_rdata[1];
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;

endmodule
